// File: rtl/seg_scan_if.sv
// Display bus between the CPU-side display register and the scan controller.
// master: drives display data, load strobe and live controls; sees pin outputs.
// slave : the scan controller.
//   en         display on
//   load       one-cycle strobe capturing disp_data / dp
//   disp_data  4 bits per digit, digit 0 in the low nibble
//   dp         decimal point per digit, 1 = lit
//   lzb        leading-zero blanking enable (live)
//   bright     on-time (bright+1)/8 of each slot (live)
//   pos_ctrl   digit select, active-low, one-cold
//   num_ctrl   segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_done one-cycle pulse in the first cycle of each frame
interface seg_scan_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  load;
   logic [4*DIGITS-1:0]   disp_data;
   logic [DIGITS-1:0]     dp;
   logic                  lzb;
   logic [2:0]            bright;
   logic [DIGITS-1:0]     pos_ctrl;
   logic [7:0]            num_ctrl;
   logic                  frame_done;

   modport master (
      output en, load, disp_data, dp, lzb, bright,
      input  pos_ctrl, num_ctrl, frame_done
   );

   modport slave (
      input  en, load, disp_data, dp, lzb, bright,
      output pos_ctrl, num_ctrl, frame_done
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller for DIGITS common-anode digits.
// Generates digit-slot timing from clk, double-buffers display data so that
// values change only at frame boundaries, and adds leading-zero blanking,
// per-digit decimal points, 8-level brightness and a global enable.
// Ports:
//   clk    system clock, rising edge
//   clr_n  asynchronous active-low reset
//   bus    seg_scan_if slave modport (see interface header)
//
// The pin outputs are registered and decoded from the next-cycle scan state,
// so in the cycle where frame_done is high the pins already select digit 0
// showing the new frame's data, and every slot on the pins is aligned with
// cnt = 0..TICK_DIV-1.
module seg_scan_ctrl #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 65536
) (
   input  logic     clk,
   input  logic     clr_n,
   seg_scan_if.slave bus
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [CW-1:0]         cnt, cnt_nxt;
   logic [IW-1:0]         idx, idx_nxt;
   logic [4*DIGITS-1:0]   act_data, act_data_nxt, shd_data;
   logic [DIGITS-1:0]     act_dp, act_dp_nxt, shd_dp;
   logic                  pend;
   logic                  slot_end, frame_end;

   logic [DIGITS-1:0]     blank;
   logic                  zero_run;
   logic [3:0]            nib;
   logic                  dp_sel, blk_sel;
   logic [CW:0]           on_lim;
   logic                  on_win;
   logic [DIGITS-1:0]     pos_nxt;
   logic [7:0]            num_nxt;

   function automatic logic [7:0] hex_font(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'h0: s = 8'hC0;
         4'h1: s = 8'hF9;
         4'h2: s = 8'hA4;
         4'h3: s = 8'hB0;
         4'h4: s = 8'h99;
         4'h5: s = 8'h92;
         4'h6: s = 8'h82;
         4'h7: s = 8'hF8;
         4'h8: s = 8'h80;
         4'h9: s = 8'h90;
         4'hA: s = 8'h88;
         4'hB: s = 8'h83;
         4'hC: s = 8'hC6;
         4'hD: s = 8'hA1;
         4'hE: s = 8'h86;
         default: s = 8'h8E;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_end  = (cnt == CW'(TICK_DIV - 1));
      frame_end = slot_end && (idx == IW'(DIGITS - 1));

      cnt_nxt = slot_end ? '0 : cnt + CW'(1);
      idx_nxt = idx;
      if (slot_end)
         idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

      // A load in the boundary cycle bypasses the shadow buffer.
      act_data_nxt = act_data;
      act_dp_nxt   = act_dp;
      if (frame_end) begin
         if (bus.load) begin
            act_data_nxt = bus.disp_data;
            act_dp_nxt   = bus.dp;
         end else if (pend) begin
            act_data_nxt = shd_data;
            act_dp_nxt   = shd_dp;
         end
      end

      // Blank from the top digit down while nibbles are zero; digit 0 never.
      blank    = '0;
      zero_run = bus.lzb;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run && (act_data_nxt[4*i +: 4] == 4'h0);
         blank[i] = zero_run;
      end

      nib     = 4'h0;
      dp_sel  = 1'b0;
      blk_sel = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_nxt == IW'(i)) begin
            nib     = act_data_nxt[4*i +: 4];
            dp_sel  = act_dp_nxt[i];
            blk_sel = blank[i];
         end
      end

      num_nxt = blk_sel ? 8'hFF : hex_font(nib);
      if (dp_sel)
         num_nxt[7] = 1'b0;

      on_lim  = (CW+1)'((int'(bus.bright) + 1) * (TICK_DIV / 8));
      on_win  = ({1'b0, cnt_nxt} < on_lim);
      pos_nxt = '1;
      if (bus.en && on_win)
         pos_nxt = ~(DIGITS'(1) << idx_nxt);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt            <= '0;
         idx            <= '0;
         act_data       <= '0;
         act_dp         <= '0;
         shd_data       <= '0;
         shd_dp         <= '0;
         pend           <= 1'b0;
         bus.pos_ctrl   <= '1;
         bus.num_ctrl   <= 8'hFF;
         bus.frame_done <= 1'b0;
      end else begin
         cnt            <= cnt_nxt;
         idx            <= idx_nxt;
         act_data       <= act_data_nxt;
         act_dp         <= act_dp_nxt;
         bus.pos_ctrl   <= pos_nxt;
         bus.num_ctrl   <= num_nxt;
         bus.frame_done <= frame_end;
         if (frame_end) begin
            pend <= 1'b0;
         end else if (bus.load) begin
            shd_data <= bus.disp_data;
            shd_dp   <= bus.dp;
            pend     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

   localparam int DIGITS   = 4;
   localparam int TICK_DIV = 8;

   logic clk;
   logic clr_n;
   int   checks;
   int   failures;

   seg_scan_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] pos_tab [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Advance until frame_done is seen (always at least one cycle).
   task automatic wait_fd();
      logic found;
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         step();
         if (bus.frame_done === 1'b1) found = 1'b1;
      end
      check("frame_done_timeout", {31'd0, found}, 32'd1);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      bus.load      = 1'b1;
      bus.disp_data = d;
      bus.dp        = p;
      step();
      bus.load      = 1'b0;
   endtask

   // Called in a frame_done cycle; checks one full frame, returns at the next.
   task automatic scan_frame(input string tag, input logic [7:0] n0, input logic [7:0] n1,
                             input logic [7:0] n2, input logic [7:0] n3);
      logic [7:0] nt [4];
      nt[0] = n0; nt[1] = n1; nt[2] = n2; nt[3] = n3;
      for (int c = 0; c < 32; c++) begin
         check({tag, "_pos"}, {28'd0, bus.pos_ctrl}, {28'd0, pos_tab[c/8]});
         check({tag, "_num"}, {24'd0, bus.num_ctrl}, {24'd0, nt[c/8]});
         check({tag, "_fd"}, {31'd0, bus.frame_done}, {31'd0, (c == 0)});
         step();
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      pos_tab[0] = 4'hE; pos_tab[1] = 4'hD; pos_tab[2] = 4'hB; pos_tab[3] = 4'h7;
      clr_n         = 1'b0;
      bus.en        = 1'b1;
      bus.load      = 1'b0;
      bus.disp_data = '0;
      bus.dp        = '0;
      bus.lzb       = 1'b0;
      bus.bright    = 3'd7;

      // reset state
      step(); step();
      check("rst_pos", {28'd0, bus.pos_ctrl}, 32'hF);
      check("rst_num", {24'd0, bus.num_ctrl}, 32'hFF);
      check("rst_fd", {31'd0, bus.frame_done}, 32'd0);
      clr_n = 1'b1;
      step();
      check("rel_pos", {28'd0, bus.pos_ctrl}, 32'hE);
      check("rel_num", {24'd0, bus.num_ctrl}, 32'hC0);
      step(); step(); step();
      clr_n = 1'b0;
      #1;
      check("async_rst_pos", {28'd0, bus.pos_ctrl}, 32'hF);
      check("async_rst_num", {24'd0, bus.num_ctrl}, 32'hFF);
      step();
      clr_n = 1'b1;
      step();
      check("rel2_pos", {28'd0, bus.pos_ctrl}, 32'hE);
      check("rel2_num", {24'd0, bus.num_ctrl}, 32'hC0);
      repeat (7) step();
      check("rel2_slot1_pos", {28'd0, bus.pos_ctrl}, 32'hD);

      // scan: 1A9B
      do_load(16'h1A9B, 4'h0);
      wait_fd();
      scan_frame("scan", 8'h83, 8'h90, 8'h88, 8'hF9);
      scan_frame("scan_rep", 8'h83, 8'h90, 8'h88, 8'hF9);

      // tear-free: load 1234 at cycle 3 of digit 1
      repeat (11) step();
      do_load(16'h1234, 4'h0);
      for (int c = 12; c < 32; c++) begin
         check("tear_old_pos", {28'd0, bus.pos_ctrl}, {28'd0, pos_tab[c/8]});
         check("tear_old_num", {24'd0, bus.num_ctrl},
               (c < 16) ? 32'h90 : (c < 24) ? 32'h88 : 32'hF9);
         step();
      end
      scan_frame("tear_new", 8'h99, 8'hB0, 8'hA4, 8'hF9);

      // load in the boundary cycle takes effect immediately
      repeat (31) step();
      check("bnd_pre_pos", {28'd0, bus.pos_ctrl}, 32'h7);
      check("bnd_pre_num", {24'd0, bus.num_ctrl}, 32'hF9);
      do_load(16'h5678, 4'h0);
      check("bnd_fd", {31'd0, bus.frame_done}, 32'd1);
      check("bnd_pos", {28'd0, bus.pos_ctrl}, 32'hE);
      check("bnd_num", {24'd0, bus.num_ctrl}, 32'h80);

      // last load before a boundary wins
      do_load(16'h1111, 4'h0);
      do_load(16'h2222, 4'h0);
      wait_fd();
      check("last_wins_num", {24'd0, bus.num_ctrl}, 32'hA4);

      // leading-zero blanking
      bus.lzb = 1'b1;
      do_load(16'h0005, 4'h0);
      wait_fd();
      scan_frame("lzb_0005", 8'h92, 8'hFF, 8'hFF, 8'hFF);
      do_load(16'h0000, 4'h0);
      wait_fd();
      scan_frame("lzb_0000", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
      do_load(16'h0105, 4'h0);
      wait_fd();
      scan_frame("lzb_0105", 8'h92, 8'hC0, 8'hF9, 8'hFF);
      do_load(16'h0005, 4'h8);
      wait_fd();
      scan_frame("lzb_dp3", 8'h92, 8'hFF, 8'hFF, 8'h7F);

      // brightness 1: on for cycles 0-1 of each slot
      bus.lzb    = 1'b0;
      bus.bright = 3'd1;
      do_load(16'h1A9B, 4'h0);
      wait_fd();
      for (int c = 0; c < 32; c++) begin
         check("bright1_pos", {28'd0, bus.pos_ctrl},
               ((c % 8) < 2) ? {28'd0, pos_tab[c/8]} : 32'hF);
         check("bright1_num", {24'd0, bus.num_ctrl},
               (c < 8) ? 32'h83 : (c < 16) ? 32'h90 : (c < 24) ? 32'h88 : 32'hF9);
         step();
      end
      bus.bright = 3'd7;

      // enable off for 1.5 frames, scanning continues
      bus.en = 1'b0;
      step();
      for (int c = 1; c < 48; c++) begin
         check("en_off_pos", {28'd0, bus.pos_ctrl}, 32'hF);
         check("en_off_fd", {31'd0, bus.frame_done}, {31'd0, (c == 32)});
         step();
      end
      bus.en = 1'b1;
      step();
      for (int c = 49; c < 64; c++) begin
         check("en_on_pos", {28'd0, bus.pos_ctrl}, {28'd0, pos_tab[(c % 32)/8]});
         check("en_on_num", {24'd0, bus.num_ctrl}, (c < 56) ? 32'h88 : 32'hF9);
         step();
      end
      check("en_on_fd", {31'd0, bus.frame_done}, 32'd1);
      check("en_on_pos0", {28'd0, bus.pos_ctrl}, 32'hE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
